// File: rtl/cntr_seq_ctrl_pkg.sv
// Shared types and default widths for the counter sequencing controller.
package cntr_seq_ctrl_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        RELOAD = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/cntr_seq_ctrl.sv
// Sequencer that drives a down-counter and converts one start request into
// N evenly spaced single-cycle pulses, one per counter terminal count.
module cntr_seq_ctrl
    import cntr_seq_ctrl_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     period,
    input  logic [CNT_W-1:0] n_pulses,
    input  logic             cntr_tc,
    output logic             cntr_load,
    output logic             cntr_re_load,
    output logic [W-1:0]     cntr_data,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_t       state;
    seq_state_t       next_state;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] cnt_inc;
    logic             start_ok;
    logic             start_bad;
    logic             tc_hit;

    assign start_ok  = (state == IDLE) && start && (period != '0) && (n_pulses != '0);
    assign start_bad = (state == IDLE) && start && ((period == '0) || (n_pulses == '0));
    assign tc_hit    = (state == RUN) && cntr_tc && !abort;
    assign cnt_inc   = (pulse_cnt == CNT_MAX) ? pulse_cnt : (pulse_cnt + CNT_ONE);

    // Next-state decode; abort returns any active state to IDLE and beats a coincident tc
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = start_ok ? LOAD : IDLE;
            LOAD:    next_state = abort ? IDLE : RUN;
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (cntr_tc) begin
                    next_state = (cnt_inc == n_reg) ? DONE : RELOAD;
                end else begin
                    next_state = RUN;
                end
            end
            RELOAD:  next_state = abort ? IDLE : RUN;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs; strobes follow the upcoming state so they line up with it, done trails DONE by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cntr_load    <= 1'b0;
            cntr_re_load <= 1'b0;
            cntr_data    <= '0;
            n_reg        <= '0;
            pulse_out    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            pulse_cnt    <= '0;
        end else begin
            cntr_load    <= (next_state == LOAD);
            cntr_re_load <= (next_state == RELOAD);
            busy         <= (next_state == LOAD) || (next_state == RUN) || (next_state == RELOAD);
            done         <= (state == DONE);
            err          <= start_bad;
            pulse_out    <= tc_hit;
            if (start_ok) begin
                cntr_data <= period;
                n_reg     <= n_pulses;
                pulse_cnt <= '0;
            end else if (tc_hit) begin
                pulse_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_cntr_seq_ctrl.sv
// Closed-loop bench: the controller drives a behavioural down-counter, and
// event timing is checked against a cycle-arithmetic model of a run.
module tb_cntr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] period;
    logic [7:0] n_pulses;
    logic       cntr_tc;
    logic       cntr_load;
    logic       cntr_re_load;
    logic [7:0] cntr_data;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] pulse_cnt;

    logic       loop_en;
    logic       force_tc;
    logic [7:0] cnt;
    logic [7:0] cap;
    logic       rec_en;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    int         pulse_q[$];
    int         done_q[$];
    int         load_q[$];
    int         reload_q[$];
    int         data_q[$];

    cntr_seq_ctrl #(.W(8), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .period       (period),
        .n_pulses     (n_pulses),
        .cntr_tc      (cntr_tc),
        .cntr_load    (cntr_load),
        .cntr_re_load (cntr_re_load),
        .cntr_data    (cntr_data),
        .pulse_out    (pulse_out),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .pulse_cnt    (pulse_cnt)
    );

    always #5 clk = ~clk;

    // Cycle index of the period that follows each rising edge
    always @(posedge clk) cyc++;

    // Behavioural 8-bit down-counter standing in for cntr_reg_8bit
    always @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
            cap <= 8'd0;
        end else if (cntr_load) begin
            cnt <= cntr_data;
            cap <= cntr_data;
        end else if (cntr_re_load) begin
            cnt <= cap;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    assign cntr_tc = loop_en ? (cnt == 8'd0) : force_tc;

    // Event recorder sampling mid-cycle
    always @(negedge clk) begin
        if (rec_en) begin
            if (pulse_out)    pulse_q.push_back(cyc);
            if (done)         done_q.push_back(cyc);
            if (cntr_re_load) reload_q.push_back(cyc);
            if (cntr_load) begin
                load_q.push_back(cyc);
                data_q.push_back(int'(cntr_data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_events();
        pulse_q.delete();
        done_q.delete();
        load_q.delete();
        reload_q.delete();
        data_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_load"}, 32'(cntr_load), 32'd0);
        check({tag, "_reload"}, 32'(cntr_re_load), 32'd0);
        check({tag, "_pulse"}, 32'(pulse_out), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Closed-loop run: with load at s+1 the counter holds period at s+2, so tc
    // lands at s+2+p and each reload costs two cycles (wrap then restart)
    task automatic run_checked(input string tag, input int p, input int n);
        int s;
        int first;
        int bound;
        clear_events();
        rec_en   = 1'b1;
        period   = 8'(p);
        n_pulses = 8'(n);
        start    = 1'b1;
        s        = cyc;
        tick();
        start = 1'b0;
        bound = n * (p + 2) + 20;
        for (int i = 0; i < bound && done_q.size() == 0; i++) tick();
        tick();
        rec_en = 1'b0;
        first  = s + 3 + p;
        check({tag, "_loads"}, 32'(load_q.size()), 32'd1);
        if (load_q.size() == 1) begin
            check({tag, "_load_cyc"}, 32'(load_q[0]), 32'(s + 1));
            check({tag, "_load_data"}, 32'(data_q[0]), 32'(p));
        end
        check({tag, "_pulses"}, 32'(pulse_q.size()), 32'(n));
        if (pulse_q.size() == n) begin
            for (int k = 0; k < n; k++)
                check($sformatf("%s_pulse%0d_cyc", tag, k), 32'(pulse_q[k]), 32'(first + k * (p + 2)));
        end
        check({tag, "_reloads"}, 32'(reload_q.size()), 32'(n - 1));
        if (reload_q.size() == n - 1) begin
            for (int k = 0; k < n - 1; k++)
                check($sformatf("%s_reload%0d_cyc", tag, k), 32'(reload_q[k]), 32'(first + k * (p + 2)));
        end
        check({tag, "_dones"}, 32'(done_q.size()), 32'd1);
        if (done_q.size() == 1)
            check({tag, "_done_cyc"}, 32'(done_q[0]), 32'(first + (n - 1) * (p + 2) + 1));
        check({tag, "_pulse_cnt"}, 32'(pulse_cnt), 32'(n));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int p;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        period   = 8'd0;
        n_pulses = 8'd0;
        loop_en  = 1'b1;
        force_tc = 1'b0;
        rec_en   = 1'b0;

        // Reset held two cycles, then quiet idle with stray counter tc
        tick();
        tick();
        check_quiet("rst");
        check("rst_data", 32'(cntr_data), 32'd0);
        check("rst_pcnt", 32'(pulse_cnt), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet("idle");
        end

        // Basic closed-loop run
        run_checked("basic", 4, 3);

        // Zero-argument starts are rejected
        period = 8'd4; n_pulses = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("zeroN_err", 32'(err), 32'd1);
        check("zeroN_busy", 32'(busy), 32'd0);
        check("zeroN_load", 32'(cntr_load), 32'd0);
        tick();
        check("zeroN_err_gone", 32'(err), 32'd0);
        check("zeroN_load2", 32'(cntr_load), 32'd0);
        period = 8'd0; n_pulses = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("zeroP_err", 32'(err), 32'd1);
        check("zeroP_busy", 32'(busy), 32'd0);
        tick();
        check_quiet("zeroP_after");

        // Abort one cycle after the second pulse
        clear_events();
        rec_en = 1'b1;
        period = 8'd10; n_pulses = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60 && pulse_q.size() < 2; i++) tick();
        check("abort_two_pulses", 32'(pulse_q.size()), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pcnt", 32'(pulse_cnt), 32'd2);
        clear_events();
        for (int i = 0; i < 30; i++) tick();
        rec_en = 1'b0;
        check("abort_no_pulse", 32'(pulse_q.size()), 32'd0);
        check("abort_no_done", 32'(done_q.size()), 32'd0);
        check("abort_no_strobe", 32'(load_q.size() + reload_q.size()), 32'd0);

        // Abort together with tc in RUN
        loop_en = 1'b0;
        period = 8'd3; n_pulses = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("col_load", 32'(cntr_load), 32'd1);
        tick();
        force_tc = 1'b1; abort = 1'b1;
        tick();
        force_tc = 1'b0; abort = 1'b0;
        check("col_pulse", 32'(pulse_out), 32'd0);
        check("col_pcnt", 32'(pulse_cnt), 32'd0);
        check("col_busy", 32'(busy), 32'd0);
        check("col_reload", 32'(cntr_re_load), 32'd0);
        tick();
        check_quiet("col_after");

        // Start while RUN is ignored
        period = 8'd5; n_pulses = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("srun_data", 32'(cntr_data), 32'd5);
        tick();
        period = 8'd2; n_pulses = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        check("srun_err", 32'(err), 32'd0);
        check("srun_load", 32'(cntr_load), 32'd0);
        check("srun_data_hold", 32'(cntr_data), 32'd5);
        check("srun_busy", 32'(busy), 32'd1);
        force_tc = 1'b1;
        tick();
        force_tc = 1'b0;
        check("srun_pulse", 32'(pulse_out), 32'd1);
        check("srun_pcnt", 32'(pulse_cnt), 32'd1);
        check("srun_done_early", 32'(done), 32'd0);
        tick();
        check("srun_done", 32'(done), 32'd1);
        check("srun_busy_end", 32'(busy), 32'd0);

        // Stray tc in IDLE is not counted
        force_tc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_pulse", 32'(pulse_out), 32'd0);
            check("stray_pcnt", 32'(pulse_cnt), 32'd1);
        end
        force_tc = 1'b0;
        loop_en  = 1'b1;
        tick();

        // Reset during RELOAD, then a short run completes
        period = 8'd3; n_pulses = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30 && !cntr_re_load; i++) tick();
        check("rmid_in_reload", 32'(cntr_re_load), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("rmid");
        check("rmid_data", 32'(cntr_data), 32'd0);
        check("rmid_pcnt", 32'(pulse_cnt), 32'd0);
        tick();
        run_checked("after_rst", 1, 2);

        // Randomised closed-loop runs
        for (int r = 0; r < 10; r++) begin
            p = int'($urandom_range(8, 1));
            n = int'($urandom_range(6, 1));
            for (int g = 0; g < int'($urandom_range(3, 0)); g++) tick();
            run_checked($sformatf("rnd%0d", r), p, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
